// File: rtl/ps2_host_tx_pkg.sv
// Shared PS/2 definitions: transmitter state encoding, common keyboard
// command bytes and the odd-parity helper used when a byte is loaded.
package ps2_host_tx_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_INHIBIT   = 3'd1,
        ST_REQ       = 3'd2,
        ST_BITS      = 3'd3,
        ST_ACK       = 3'd4,
        ST_WAIT_IDLE = 3'd5
    } state_t;

    localparam logic [7:0] CMD_SET_LEDS = 8'hED;
    localparam logic [7:0] CMD_ENABLE   = 8'hF4;
    localparam logic [7:0] CMD_RESET    = 8'hFF;

    // Parity bit that makes the total count of ones in data+parity odd.
    function automatic logic oddParity(input logic [7:0] i_data);
        return ~^i_data;
    endfunction

endpackage

// File: rtl/ps2_line_sync.sv
// Two-flop synchronizers for the PS/2 clock and data pads plus a one-cycle
// falling-edge strobe on the synchronized clock. Shared with the receiver.
module ps2_line_sync (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_ps2Clk,
    input  logic i_ps2Data,
    output logic o_clkSync,
    output logic o_dataSync,
    output logic o_fallEdge
);

    logic [1:0] r_clkSync;
    logic [1:0] r_dataSync;
    logic       r_clkPrev;

    // Synchronize both lines; reset to 1 so a released bus shows no edge.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_clkSync  <= 2'b11;
            r_dataSync <= 2'b11;
            r_clkPrev  <= 1'b1;
        end else begin
            r_clkSync  <= {r_clkSync[0], i_ps2Clk};
            r_dataSync <= {r_dataSync[0], i_ps2Data};
            r_clkPrev  <= r_clkSync[1];
        end
    end

    assign o_clkSync  = r_clkSync[1];
    assign o_dataSync = r_dataSync[1];
    assign o_fallEdge = r_clkPrev & ~r_clkSync[1];

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: inhibit, request-to-send, 8 data bits
// LSB first, odd parity, stop, then checks the device ACK and waits for idle.
module ps2_host_tx
    import ps2_host_tx_pkg::*;
#(
    parameter int counterBits   = 16,
    parameter int inhibitCycles = 1200,
    parameter int timeoutCycles = 24000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ps2Clk,
    input  logic       ps2Data,
    output logic       ps2ClkOe,
    output logic       ps2DataOe,
    input  logic [7:0] txData,
    input  logic       start,
    output logic       busy,
    output logic       done,
    output logic       ackError,
    output logic       timeout
);

    localparam logic [counterBits-1:0] INHIBIT_LAST = counterBits'(inhibitCycles - 1);
    localparam logic [counterBits-1:0] TIMEOUT_LAST = counterBits'(timeoutCycles - 1);

    state_t                 r_state;
    state_t                 w_next;
    logic [3:0]             r_bitCnt;
    logic [9:0]             r_shift;
    logic [counterBits-1:0] r_cnt;
    logic                   r_dataOe;
    logic                   r_done;
    logic                   r_ackError;
    logic                   r_timeout;

    logic w_clkSync;
    logic w_dataSync;
    logic w_fallEdge;
    logic w_expired;
    logic w_accept;
    logic w_shiftBit;
    logic w_done;
    logic w_ackErr;
    logic w_tmo;

    ps2_line_sync u_sync (
        .i_clk      (clk),
        .i_rst_n    (reset),
        .i_ps2Clk   (ps2Clk),
        .i_ps2Data  (ps2Data),
        .o_clkSync  (w_clkSync),
        .o_dataSync (w_dataSync),
        .o_fallEdge (w_fallEdge)
    );

    // A device edge in the same cycle as expiry takes priority over the timeout.
    assign w_expired = (r_cnt == TIMEOUT_LAST) && !w_fallEdge;

    // State register; async reset drops the frame and releases both lines.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_state <= ST_IDLE;
        else        r_state <= w_next;
    end

    // Next-state decode and per-cycle event strobes.
    always_comb begin
        w_next     = r_state;
        w_accept   = 1'b0;
        w_shiftBit = 1'b0;
        w_done     = 1'b0;
        w_ackErr   = 1'b0;
        w_tmo      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_accept = 1'b1;
                    w_next   = ST_INHIBIT;
                end
            end
            ST_INHIBIT: begin
                if (r_cnt == INHIBIT_LAST) w_next = ST_REQ;
            end
            ST_REQ: w_next = ST_BITS;
            ST_BITS: begin
                if (w_fallEdge) begin
                    w_shiftBit = 1'b1;
                    if (r_bitCnt == 4'd9) w_next = ST_ACK;
                end else if (w_expired) begin
                    w_tmo  = 1'b1;
                    w_next = ST_IDLE;
                end
            end
            ST_ACK: begin
                if (w_fallEdge) begin
                    if (w_dataSync) begin
                        w_ackErr = 1'b1;
                        w_next   = ST_IDLE;
                    end else begin
                        w_next = ST_WAIT_IDLE;
                    end
                end else if (w_expired) begin
                    w_tmo  = 1'b1;
                    w_next = ST_IDLE;
                end
            end
            ST_WAIT_IDLE: begin
                if (w_clkSync && w_dataSync) begin
                    w_done = 1'b1;
                    w_next = ST_IDLE;
                end else if (w_expired) begin
                    w_tmo  = 1'b1;
                    w_next = ST_IDLE;
                end
            end
            default: w_next = ST_IDLE;
        endcase
    end

    // Control datapath: cycle counter, bit counter, data drive and result pulses.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cnt      <= '0;
            r_bitCnt   <= 4'd0;
            r_dataOe   <= 1'b0;
            r_done     <= 1'b0;
            r_ackError <= 1'b0;
            r_timeout  <= 1'b0;
        end else begin
            if (w_fallEdge || (w_next != r_state)) r_cnt <= '0;
            else if (r_state != ST_IDLE)           r_cnt <= r_cnt + 1'b1;

            if (r_state == ST_REQ) r_bitCnt <= 4'd0;
            else if (w_shiftBit)   r_bitCnt <= r_bitCnt + 4'd1;

            // Start bit is driven from REQ and held until the first device edge.
            if (w_next == ST_REQ)       r_dataOe <= 1'b1;
            else if (w_shiftBit)        r_dataOe <= ~r_shift[0];
            else if (w_next != ST_BITS) r_dataOe <= 1'b0;

            r_done     <= w_done;
            r_ackError <= w_ackErr;
            r_timeout  <= w_tmo;
        end
    end

    // Frame shifter {stop, parity, data}; pure data, loaded on accept.
    always_ff @(posedge clk) begin
        if (w_accept)        r_shift <= {1'b1, oddParity(txData), txData};
        else if (w_shiftBit) r_shift <= {1'b1, r_shift[9:1]};
    end

    assign ps2ClkOe  = (r_state == ST_INHIBIT) || (r_state == ST_REQ);
    assign ps2DataOe = r_dataOe;
    assign busy      = (r_state != ST_IDLE);
    assign done      = r_done;
    assign ackError  = r_ackError;
    assign timeout   = r_timeout;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: open-drain bus model plus a PS/2 device model that
// clocks the frame, samples on rising edges and optionally ACKs.
module tb_ps2_host_tx;
    import ps2_host_tx_pkg::*;

    localparam int INH  = 60;
    localparam int TMO  = 400;
    localparam int HALF = 40;

    typedef struct {
        logic [7:0] data;
        logic       ack;
        logic       par;
        int         exp_done;
        int         exp_ackerr;
    } vec_t;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       dev_clk = 1'b1;
    logic       dev_data = 1'b1;
    logic       start = 1'b0;
    logic [7:0] txData = 8'h00;
    logic       ps2Clk, ps2Data, ps2ClkOe, ps2DataOe;
    logic       busy, done, ackError, timeout;

    int n_checks = 0;
    int n_errors = 0;
    int n_done = 0;
    int n_ackerr = 0;
    int n_tmo = 0;

    vec_t vecs[5];

    assign ps2Clk  = dev_clk & ~ps2ClkOe;
    assign ps2Data = dev_data & ~ps2DataOe;

    always #5 clk = ~clk;

    ps2_host_tx #(
        .counterBits   (16),
        .inhibitCycles (INH),
        .timeoutCycles (TMO)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .ps2Clk    (ps2Clk),
        .ps2Data   (ps2Data),
        .ps2ClkOe  (ps2ClkOe),
        .ps2DataOe (ps2DataOe),
        .txData    (txData),
        .start     (start),
        .busy      (busy),
        .done      (done),
        .ackError  (ackError),
        .timeout   (timeout)
    );

    always @(negedge clk) begin
        if (done === 1'b1)     n_done++;
        if (ackError === 1'b1) n_ackerr++;
        if (timeout === 1'b1)  n_tmo++;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic host_start(input logic [7:0] b);
        @(negedge clk);
        check("idle_before_start", busy, 1'b0);
        txData = b;
        start  = 1'b1;
        @(negedge clk);
        start  = 1'b0;
        check("busy_after_start", busy, 1'b1);
    endtask

    task automatic device_frame(input logic [7:0] b, input logic par, input logic ack,
                                input bit inject, input int abort_at,
                                input int exp_done, input int exp_ackerr);
        int d0, a0, t0, held, k;
        logic [9:0] bits;
        d0 = n_done; a0 = n_ackerr; t0 = n_tmo;
        bits = '0;
        k = 0;
        while (ps2ClkOe !== 1'b1 && k < 1000) begin @(negedge clk); k++; end
        held = 0;
        while (ps2ClkOe === 1'b1 && held < 1000) begin
            if (inject && held == 5) begin
                txData = 8'h00;
                start  = 1'b1;
            end else begin
                start  = 1'b0;
            end
            @(negedge clk);
            held++;
        end
        start = 1'b0;
        check("inhibit_len_ok", held >= INH, 1'b1);
        check("start_bit", ps2Data, 1'b0);
        for (int i = 0; i < 10; i++) begin
            repeat (HALF) @(negedge clk);
            dev_clk = 1'b0;
            if (i == abort_at) begin
                repeat (10) @(negedge clk);
                return;
            end
            repeat (HALF) @(negedge clk);
            dev_clk = 1'b1;
            bits[i] = ps2Data;
        end
        check("frame_bits", bits, {1'b1, par, b});
        check("host_clk_released", ps2ClkOe, 1'b0);
        if (ack) dev_data = 1'b0;
        repeat (HALF) @(negedge clk);
        dev_clk = 1'b0;
        repeat (HALF) @(negedge clk);
        dev_clk = 1'b1;
        repeat (HALF) @(negedge clk);
        dev_data = 1'b1;
        k = 0;
        while (busy !== 1'b0 && k < 200) begin @(negedge clk); k++; end
        #1;
        check("busy_end", busy, 1'b0);
        check("done_count", n_done - d0, exp_done);
        check("ackerr_count", n_ackerr - a0, exp_ackerr);
        check("tmo_count", n_tmo - t0, 0);
        check("end_clkOe", ps2ClkOe, 1'b0);
        check("end_dataOe", ps2DataOe, 1'b0);
    endtask

    initial begin
        #800000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int d0, t0, k, n;
        vecs[0] = '{CMD_SET_LEDS, 1'b1, 1'b1, 1, 0};
        vecs[1] = '{8'h01,        1'b1, 1'b0, 1, 0};
        vecs[2] = '{CMD_RESET,    1'b1, 1'b1, 1, 0};
        vecs[3] = '{CMD_SET_LEDS, 1'b0, 1'b1, 0, 1};
        vecs[4] = '{CMD_ENABLE,   1'b1, 1'b0, 1, 0};

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_clkOe", ps2ClkOe, 1'b0);
        check("rst_dataOe", ps2DataOe, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_ackError", ackError, 1'b0);
        check("rst_timeout", timeout, 1'b0);
        reset = 1'b1;
        repeat (3) @(negedge clk);

        // Table of complete frames, with and without device ACK
        for (int v = 0; v < 5; v++) begin
            host_start(vecs[v].data);
            device_frame(vecs[v].data, vecs[v].par, vecs[v].ack, 1'b0, -1,
                         vecs[v].exp_done, vecs[v].exp_ackerr);
        end

        // Device never clocks after request-to-send
        d0 = n_done; t0 = n_tmo;
        host_start(CMD_RESET);
        k = 0;
        while (ps2ClkOe === 1'b1 && k < 1000) begin @(negedge clk); k++; end
        n = 0;
        while (timeout !== 1'b1 && n < TMO + 100) begin @(negedge clk); n++; end
        check("timeout_latency", n, TMO);
        #1;
        check("tmo_clkOe", ps2ClkOe, 1'b0);
        check("tmo_dataOe", ps2DataOe, 1'b0);
        check("tmo_busy", busy, 1'b0);
        check("tmo_pulses", n_tmo - t0, 1);
        check("tmo_no_done", n_done - d0, 0);

        // Asynchronous reset during bit 4 of 0xED
        host_start(CMD_SET_LEDS);
        device_frame(CMD_SET_LEDS, 1'b1, 1'b1, 1'b0, 4, 0, 0);
        check("pre_reset_dataOe", ps2DataOe, 1'b1);
        #2 reset = 1'b0;
        #1;
        check("async_rst_clkOe", ps2ClkOe, 1'b0);
        check("async_rst_dataOe", ps2DataOe, 1'b0);
        check("async_rst_busy", busy, 1'b0);
        dev_clk  = 1'b1;
        dev_data = 1'b1;
        repeat (5) @(negedge clk);
        reset = 1'b1;
        repeat (3) @(negedge clk);
        host_start(CMD_ENABLE);
        device_frame(CMD_ENABLE, 1'b0, 1'b1, 1'b0, -1, 1, 0);

        // Start while busy is ignored; start right after done is accepted
        host_start(CMD_SET_LEDS);
        device_frame(CMD_SET_LEDS, 1'b1, 1'b1, 1'b1, -1, 1, 0);
        host_start(8'h01);
        device_frame(8'h01, 1'b0, 1'b1, 1'b0, -1, 1, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
